// File: rtl/week_5_encoder_rr_arbiter.sv
// Round-robin arbiter for 4 requesters with registered one-hot grant and
// encoded index (0001->00, 0010->01, 0100->10, 1000->11).
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req[3:0]    request lines, req[i]=1 means requester i wants the resource
//   done        current owner finished (only looked at while granted)
//   grant[3:0]  one-hot grant, 0000 when idle
//   grant_idx   encoded grant index, 00 when idle
//   grant_valid some requester owns the resource
//   timeout     one-cycle pulse after an owner was forcibly released
module week_5_encoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int unsigned CNT_RAW   = $clog2(MAX_HOLD + 1);
    localparam int unsigned CNT_W     = (CNT_RAW == 0) ? 1 : CNT_RAW;
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         grant_q, grant_d;
    logic [1:0]         grant_idx_q, grant_idx_d;
    logic               grant_valid_q, grant_valid_d;
    logic               timeout_q, timeout_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic               pick_found;
    logic [1:0]         pick_idx;
    logic [1:0]         cand;
    logic               rel_done;
    logic               rel_withdraw;
    logic               rel_max;
    logic               release_c;

    // Circular first-set search starting at ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Release conditions for the current owner.
    always_comb begin
        rel_done     = done;
        rel_withdraw = !req[grant_idx_q];
        rel_max      = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(HOLD_LAST));
        release_c    = rel_done || rel_withdraw || rel_max;
    end

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d       = 4'b0001 << pick_idx;
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = S_GRANT;
                end
            end
            S_GRANT: begin
                if (release_c) begin
                    grant_d       = 4'b0000;
                    grant_idx_d   = 2'd0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                    ptr_d         = grant_idx_q + 2'd1;
                    // Forced release only when nothing else would have released.
                    timeout_d     = rel_max && !rel_done && !rel_withdraw;
                    state_d       = S_IDLE;
                end else begin
                    hold_cnt_d    = CNT_W'(hold_cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_q       <= 4'b0000;
            grant_idx_q   <= 2'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            ptr_q         <= 2'd0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_week_5_encoder_rr_arbiter.sv
// Directed bench for the round-robin arbiter.
// Observed vector layout: {grant[3:0], grant_idx[1:0], grant_valid, timeout}.
module tb_week_5_encoder_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    logic [7:0] obs;
    int         pass_cnt;
    int         total_cnt;

    week_5_encoder_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    assign obs = {grant, grant_idx, grant_valid, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] IDLE_V = 8'b0000_00_0_0;
    localparam logic [7:0] TO_V   = 8'b0000_00_0_1;
    localparam logic [7:0] G0_V   = 8'b0001_00_1_0;
    localparam logic [7:0] G1_V   = 8'b0010_01_1_0;
    localparam logic [7:0] G2_V   = 8'b0100_10_1_0;
    localparam logic [7:0] G3_V   = 8'b1000_11_1_0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        done = 1'b0;
        tick();
        total_cnt++;
        if (obs !== IDLE_V) $display("FAIL reset_state: got %b want %b", obs, IDLE_V);
        else pass_cnt++;
        rst = 1'b0;
        req = 4'b0001;
        tick();
        total_cnt++;
        if (obs !== G0_V) $display("FAIL first_grant: got %b want %b", obs, G0_V);
        else pass_cnt++;
        done = 1'b1;
        tick();
        total_cnt++;
        if (obs !== IDLE_V) $display("FAIL done_release: got %b want %b", obs, IDLE_V);
        else pass_cnt++;
        done = 1'b0;
        req  = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_g [5];
        exp_g[0] = G0_V; exp_g[1] = G1_V; exp_g[2] = G2_V;
        exp_g[3] = G3_V; exp_g[4] = G0_V;
        do_reset();
        req  = 4'b1111;
        done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (obs !== exp_g[i]) $display("FAIL rr_grant_%0d: got %b want %b", i, obs, exp_g[i]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (obs !== IDLE_V) $display("FAIL rr_gap_%0d: got %b want %b", i, obs, IDLE_V);
            else pass_cnt++;
        end
        done = 1'b0;
        req  = 4'b0000;
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1000;
        tick();
        total_cnt++;
        if (obs !== G3_V) $display("FAIL wrap_owner3: got %b want %b", obs, G3_V);
        else pass_cnt++;
        req  = 4'b1001;
        done = 1'b1;
        tick();
        total_cnt++;
        if (obs !== IDLE_V) $display("FAIL wrap_release: got %b want %b", obs, IDLE_V);
        else pass_cnt++;
        done = 1'b0;
        tick();
        total_cnt++;
        if (obs !== G0_V) $display("FAIL wrap_to_0: got %b want %b", obs, G0_V);
        else pass_cnt++;
        // Non-owner request change must not disturb the grant.
        req = 4'b0011;
        tick();
        total_cnt++;
        if (obs !== G0_V) $display("FAIL non_owner_ignored: got %b want %b", obs, G0_V);
        else pass_cnt++;
        req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req  = 4'b0100;
        done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total_cnt++;
            if (obs !== G2_V) $display("FAIL hold_cycle_%0d: got %b want %b", i, obs, G2_V);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (obs !== TO_V) $display("FAIL timeout_pulse: got %b want %b", obs, TO_V);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (obs !== G2_V) $display("FAIL regrant_after_to: got %b want %b", obs, G2_V);
        else pass_cnt++;
        // Owner withdraws: normal release, no timeout.
        req = 4'b0000;
        tick();
        total_cnt++;
        if (obs !== IDLE_V) $display("FAIL withdraw_release: got %b want %b", obs, IDLE_V);
        else pass_cnt++;
    endtask

    task automatic test_done_at_max();
        do_reset();
        req  = 4'b0010;
        done = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        total_cnt++;
        if (obs !== G1_V) $display("FAIL held_to_last: got %b want %b", obs, G1_V);
        else pass_cnt++;
        done = 1'b1;
        tick();
        total_cnt++;
        if (obs !== IDLE_V) $display("FAIL done_at_max: got %b want %b", obs, IDLE_V);
        else pass_cnt++;
        done = 1'b0;
        req  = 4'b0000;
        // done while idle has no effect.
        done = 1'b1;
        tick();
        total_cnt++;
        if (obs !== IDLE_V) $display("FAIL idle_done_ignored: got %b want %b", obs, IDLE_V);
        else pass_cnt++;
        done = 1'b0;
    endtask

    task automatic test_mid_grant_reset();
        do_reset();
        req = 4'b0001;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b1111;
        tick();
        total_cnt++;
        if (obs !== G1_V) $display("FAIL pre_reset_grant: got %b want %b", obs, G1_V);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (obs !== IDLE_V) $display("FAIL mid_grant_reset: got %b want %b", obs, IDLE_V);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (obs !== G0_V) $display("FAIL ptr_restored: got %b want %b", obs, G0_V);
        else pass_cnt++;
        req = 4'b0000;
        tick();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        req       = 4'b0000;
        done      = 1'b0;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_timeout();
        test_done_at_max();
        test_mid_grant_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
